// File: rtl/clock_pkg.sv
// Shared definitions for the clock-setting path: digit widths, BCD limits,
// controller state encoding and the time-of-day helpers.
package clock_pkg;

   localparam int HOUR1_W = 2;
   localparam int HOUR2_W = 4;
   localparam int MIN1_W  = 3;
   localparam int MIN2_W  = 4;
   localparam int SEC1_W  = 3;
   localparam int SEC2_W  = 4;

   localparam logic [HOUR1_W-1:0] HOUR1_MAX       = 2'd2;
   localparam logic [HOUR2_W-1:0] HOUR_WRAP_UNITS = 4'd3;
   localparam logic [MIN1_W-1:0]  TENS_MAX        = 3'd5;
   localparam logic [MIN2_W-1:0]  UNITS_MAX       = 4'd9;

   typedef enum logic {
      WAIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic [HOUR1_W-1:0] hour1;
      logic [HOUR2_W-1:0] hour2;
      logic [MIN1_W-1:0]  min1;
      logic [MIN2_W-1:0]  min2;
      logic [SEC1_W-1:0]  sec1;
      logic [SEC2_W-1:0]  sec2;
   } time_t;

   // A set value is usable only if every digit is a legal 24-hour BCD digit.
   function automatic logic time_valid(input time_t t);
      logic hour_ok;
      hour_ok = (t.hour1 <= HOUR1_MAX) && (t.hour2 <= UNITS_MAX) &&
                ((t.hour1 < HOUR1_MAX) || (t.hour2 <= HOUR_WRAP_UNITS));
      return hour_ok &&
             (t.min1 <= TENS_MAX) && (t.min2 <= UNITS_MAX) &&
             (t.sec1 <= TENS_MAX) && (t.sec2 <= UNITS_MAX);
   endfunction

   // Advance by one second with a cascaded BCD carry; 23:59:59 wraps to 00:00:00.
   function automatic time_t time_inc(input time_t t);
      time_t r;
      r = t;
      if (t.sec2 != UNITS_MAX) begin
         r.sec2 = t.sec2 + 4'd1;
      end else begin
         r.sec2 = '0;
         if (t.sec1 != TENS_MAX) begin
            r.sec1 = t.sec1 + 3'd1;
         end else begin
            r.sec1 = '0;
            if (t.min2 != UNITS_MAX) begin
               r.min2 = t.min2 + 4'd1;
            end else begin
               r.min2 = '0;
               if (t.min1 != TENS_MAX) begin
                  r.min1 = t.min1 + 3'd1;
               end else begin
                  r.min1 = '0;
                  if ((t.hour1 == HOUR1_MAX) && (t.hour2 == HOUR_WRAP_UNITS)) begin
                     r.hour1 = '0;
                     r.hour2 = '0;
                  end else if (t.hour2 == UNITS_MAX) begin
                     r.hour2 = '0;
                     r.hour1 = t.hour1 + 2'd1;
                  end else begin
                     r.hour2 = t.hour2 + 4'd1;
                  end
               end
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/time_keeper_tick_gen.sv
// Prescaler: counts enabled cycles and flags the terminal count, on which it
// wraps to zero. A clear overrides counting.
module tick_gen #(
   parameter int TICKS_PER_SEC = 100000000,
   parameter int PRESC_W       = 27
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic clr,
   output logic tick
);

   logic [PRESC_W-1:0] count;

   // Terminal flag; the consumer registers it, so it stays internal to the block.
   assign tick = en && (count == PRESC_W'(TICKS_PER_SEC - 1));

   // Prescaler count; clear has priority, then wrap on terminal, else increment.
   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge (synchronous), so it lives inside the clocked branch, not the sensitivity list.
      if (!reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= tick ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/time_keeper.sv
// Wall-clock time keeper: loads validated HH:MM:SS digits on a rising edge of
// load and then advances once per second in 24-hour format.
module time_keeper
   import clock_pkg::*;
#(
   parameter int TICKS_PER_SEC = 100000000,
   parameter int PRESC_W       = 27
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               run,
   input  logic [HOUR1_W-1:0] set_hour1,
   input  logic [HOUR2_W-1:0] set_hour2,
   input  logic [MIN1_W-1:0]  set_min1,
   input  logic [MIN2_W-1:0]  set_min2,
   input  logic [SEC1_W-1:0]  set_sec1,
   input  logic [SEC2_W-1:0]  set_sec2,
   output logic [HOUR1_W-1:0] hour1,
   output logic [HOUR2_W-1:0] hour2,
   output logic [MIN1_W-1:0]  min1,
   output logic [MIN2_W-1:0]  min2,
   output logic [SEC1_W-1:0]  sec1,
   output logic [SEC2_W-1:0]  sec2,
   output logic               sec_tick,
   output logic               load_err,
   output logic               running
);

   state_t state;
   time_t  cur;
   time_t  set_t;
   logic   load_q;
   logic   load_edge;
   logic   load_ok;
   logic   tick;

   assign set_t     = '{hour1: set_hour1, hour2: set_hour2, min1: set_min1,
                        min2: set_min2, sec1: set_sec1, sec2: set_sec2};
   assign load_edge = load & ~load_q;
   assign load_ok   = time_valid(set_t);

   // A valid load restarts the second so the loaded time is shown for a full second.
   tick_gen #(
      .TICKS_PER_SEC (TICKS_PER_SEC),
      .PRESC_W       (PRESC_W)
   ) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .en    ((state == RUN) && run),
      .clr   (load_edge && load_ok),
      .tick  (tick)
   );

   // Controller: load edge detection, load/advance of the time and the status pulses.
   always_ff @(posedge clk) begin
      // NOTE: every register here uses <= so all of them see pre-edge values, independent of statement order.
      if (!reset) begin
         state    <= WAIT;
         cur      <= '0;
         load_q   <= 1'b0;
         sec_tick <= 1'b0;
         load_err <= 1'b0;
      end else begin
         load_q   <= load;
         sec_tick <= 1'b0;
         load_err <= 1'b0;
         if (load_edge && load_ok) begin
            // A load wins over a coincident terminal count.
            cur   <= set_t;
            state <= RUN;
         end else begin
            if (load_edge) begin
               load_err <= 1'b1;
            end
            if (tick) begin
               cur      <= time_inc(cur);
               sec_tick <= 1'b1;
            end
         end
      end
   end

   assign hour1   = cur.hour1;
   assign hour2   = cur.hour2;
   assign min1    = cur.min1;
   assign min2    = cur.min2;
   assign sec1    = cur.sec1;
   assign sec2    = cur.sec2;
   assign running = (state == RUN);

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with a seconds-of-day reference model.
module tb_time_keeper;

   localparam int T = 4;

   logic       clk = 1'b0;
   logic       reset, load, run;
   logic [1:0] set_hour1;
   logic [3:0] set_hour2;
   logic [2:0] set_min1;
   logic [3:0] set_min2;
   logic [2:0] set_sec1;
   logic [3:0] set_sec2;
   logic [1:0] hour1;
   logic [3:0] hour2;
   logic [2:0] min1;
   logic [3:0] min2;
   logic [2:0] sec1;
   logic [3:0] sec2;
   logic       sec_tick, load_err, running;

   time_keeper #(.TICKS_PER_SEC(T), .PRESC_W(3)) dut (
      .clk(clk), .reset(reset), .load(load), .run(run),
      .set_hour1(set_hour1), .set_hour2(set_hour2),
      .set_min1(set_min1), .set_min2(set_min2),
      .set_sec1(set_sec1), .set_sec2(set_sec2),
      .hour1(hour1), .hour2(hour2), .min1(min1), .min2(min2),
      .sec1(sec1), .sec2(sec2),
      .sec_tick(sec_tick), .load_err(load_err), .running(running)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int ticks_seen = 0;
   bit chk_en = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: time as seconds since midnight, prescaler as an integer.
   int m_secs, m_pre;
   bit m_run, m_load_q, m_tick, m_err;

   function automatic bit legal(int h1, int h2, int m1, int m2, int s1, int s2);
      return (h1 <= 2) && (h2 <= 9) && (h1 * 10 + h2 <= 23) &&
             (m1 <= 5) && (m2 <= 9) && (s1 <= 5) && (s2 <= 9);
   endfunction

   always @(posedge clk) begin
      bit edge_seen;
      if (!reset) begin
         m_secs = 0; m_pre = 0; m_run = 0; m_load_q = 0; m_tick = 0; m_err = 0;
      end else begin
         edge_seen = load && !m_load_q;
         m_load_q  = load;
         m_tick    = 0;
         m_err     = 0;
         if (edge_seen && legal(set_hour1, set_hour2, set_min1, set_min2, set_sec1, set_sec2)) begin
            m_secs = (set_hour1 * 10 + set_hour2) * 3600 +
                     (set_min1 * 10 + set_min2) * 60 + set_sec1 * 10 + set_sec2;
            m_pre  = 0;
            m_run  = 1;
         end else begin
            if (edge_seen) m_err = 1;
            if (m_run && run) begin
               if (m_pre == T - 1) begin
                  m_pre  = 0;
                  m_secs = (m_secs + 1) % 86400;
                  m_tick = 1;
               end else begin
                  m_pre++;
               end
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("hour1",    int'(hour1),    (m_secs / 3600) / 10);
         check("hour2",    int'(hour2),    (m_secs / 3600) % 10);
         check("min1",     int'(min1),     ((m_secs / 60) % 60) / 10);
         check("min2",     int'(min2),     ((m_secs / 60) % 60) % 10);
         check("sec1",     int'(sec1),     (m_secs % 60) / 10);
         check("sec2",     int'(sec2),     (m_secs % 60) % 10);
         check("sec_tick", int'(sec_tick), int'(m_tick));
         check("load_err", int'(load_err), int'(m_err));
         check("running",  int'(running),  int'(m_run));
         if (sec_tick) ticks_seen++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic set_time(input int h1, h2, m1, m2, s1, s2);
      set_hour1 = 2'(h1); set_hour2 = 4'(h2);
      set_min1  = 3'(m1); set_min2  = 4'(m2);
      set_sec1  = 3'(s1); set_sec2  = 4'(s2);
   endtask

   task automatic check_time(input string name, input int h, m, s);
      check({name, "_hh"}, int'(hour1) * 10 + int'(hour2), h);
      check({name, "_mm"}, int'(min1) * 10 + int'(min2), m);
      check({name, "_ss"}, int'(sec1) * 10 + int'(sec2), s);
   endtask

   initial begin
      reset = 1'b0; load = 1'b0; run = 1'b1;
      set_time(0, 0, 0, 0, 0, 0);
      cyc(1);
      chk_en = 1;
      cyc(1);
      reset = 1'b1;

      // 1: idle after reset, no load
      cyc(20);
      check_time("idle", 0, 0, 0);
      check("idle_running", int'(running), 0);
      check("idle_ticks", ticks_seen, 0);

      // 2: load 12:34:56 and count
      set_time(1, 2, 3, 4, 5, 6);
      load = 1'b1;
      ticks_seen = 0;
      cyc(1);
      check("load_running", int'(running), 1);
      check_time("loaded", 12, 34, 56);
      cyc(4);
      check("first_tick", int'(sec_tick), 1);
      check_time("plus1", 12, 34, 57);
      cyc(12);
      check_time("plus4", 12, 35, 0);

      // 3: midnight rollover
      load = 1'b0;
      cyc(1);
      set_time(2, 3, 5, 9, 5, 8);
      load = 1'b1;
      cyc(1);
      ticks_seen = 0;
      cyc(8);
      check_time("midnight", 0, 0, 0);
      check("midnight_ticks", ticks_seen, 2);

      // 4: rejected loads in WAIT
      reset = 1'b0; load = 1'b0;
      cyc(1);
      reset = 1'b1;
      set_time(2, 4, 0, 0, 0, 0);
      load = 1'b1;
      cyc(1);
      check("err_hour", int'(load_err), 1);
      check("err_hour_running", int'(running), 0);
      cyc(1);
      check("err_hour_pulse", int'(load_err), 0);
      load = 1'b0;
      cyc(1);
      set_time(1, 2, 0, 10, 0, 0);
      load = 1'b1;
      cyc(1);
      check("err_min", int'(load_err), 1);
      check_time("err_min_time", 0, 0, 0);
      cyc(1);
      check("err_min_pulse", int'(load_err), 0);

      // 5: held load gives one event; run gating freezes and resumes
      reset = 1'b0; load = 1'b0;
      cyc(1);
      reset = 1'b1;
      set_time(0, 1, 0, 2, 0, 3);
      load = 1'b1;
      ticks_seen = 0;
      cyc(30);
      check("held_ticks", ticks_seen, 7);
      check_time("held", 1, 2, 10);
      run = 1'b0;
      cyc(10);
      check_time("frozen", 1, 2, 10);
      check("frozen_ticks", ticks_seen, 7);
      run = 1'b1;
      cyc(2);
      check("resume_early", ticks_seen, 7);
      cyc(1);
      check("resume_tick", int'(sec_tick), 1);
      check_time("resumed", 1, 2, 11);

      // 6a: reset mid-count
      load = 1'b0;
      cyc(1);
      set_time(0, 9, 5, 9, 5, 9);
      load = 1'b1;
      cyc(2);
      reset = 1'b0; load = 1'b0;
      cyc(1);
      check_time("reset_mid", 0, 0, 0);
      check("reset_running", int'(running), 0);
      reset = 1'b1;

      // 6b: load edge coinciding with the prescaler terminal
      set_time(1, 0, 0, 0, 0, 0);
      load = 1'b1;
      cyc(1);
      load = 1'b0;
      cyc(1);
      set_time(0, 5, 0, 6, 0, 7);
      cyc(2);
      load = 1'b1;
      ticks_seen = 0;
      cyc(1);
      check_time("collide", 5, 6, 7);
      check("collide_tick", int'(sec_tick), 0);
      cyc(4);
      check("after_collide_tick", int'(sec_tick), 1);
      check_time("after_collide", 5, 6, 8);

      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
